data_ram_responder: RTL
=======================

Name: data_ram_responder

Overview:
- Memory-side responder for the core's RAM control port (ram_en / ram_write_en / ram_addr / ram_write_data in, ram_read_data back).
- Holds a word-organised on-chip data RAM with per-byte write lanes.
- Inserts a configurable number of wait states by driving the core-wide stall input, so slower memory timing can be modelled without changing the pipeline.
- Sits at top level between Core and the stall OR-tree.

Parameters:
- ADDR_WIDTH, 10, word-address width; RAM holds 2^ADDR_WIDTH 32-bit words.
- WAIT_STATES, 2, stall cycles inserted per access (0..15); 0 gives single-cycle access.
- BASE_ADDR, 32'h0000_0000, byte base address of the RAM window; must be aligned to 2^(ADDR_WIDTH+2).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- ram_en  in  1  access request from core MEM stage.
- ram_write_en  in  4  byte-lane write enables; bit i writes bits [8i+7:8i]; all-zero means read.
- ram_addr  in  32  byte address; bits [1:0] ignored.
- ram_write_data  in  32  write data, lane-aligned by core.
- ram_read_data  out  32  registered read data, full word.
- stall  out  1  wait request to pipeline controller; combinational.
- access_err  out  1  registered one-cycle pulse for an out-of-window access.

Behaviour:
- Reset (async, any time): ram_read_data=0, access_err=0, wait counter cnt=0, so stall=0 immediately. Memory array contents are not reset. An in-flight access is aborted and no write is committed.
- Address decode:
  - in_range = (ram_addr[31:ADDR_WIDTH+2] == BASE_ADDR[31:ADDR_WIDTH+2]).
  - Word index = ram_addr[ADDR_WIDTH+1:2].
- Counter FSM, cnt in 0..WAIT_STATES, 4 bits:
  - IDLE/COUNT: ram_en=1 and cnt<WAIT_STATES -> cnt<=cnt+1; stall=1.
  - COMPLETE: ram_en=1 and cnt==WAIT_STATES -> stall=0; access is performed at this edge; cnt<=0.
  - ram_en=0 -> cnt<=0, stall=0, no access, ram_read_data holds.
- stall = ram_en & (cnt != WAIT_STATES). With WAIT_STATES=0, stall is never asserted.
- Request stability: the core holds the request stable while stalled. Values sampled at the COMPLETE edge are the ones used. If ram_en drops mid-wait, the access is aborted with no side effects.
- Access at the COMPLETE edge:
  - Write (any ram_write_en bit set, in_range): only the enabled lanes of mem[index] are updated. ram_read_data holds its previous value.
  - Read (ram_write_en==0, in_range): ram_read_data <= mem[index] at that edge; valid in the following cycle (same contract for all WAIT_STATES).
  - Out of range: no write; reads load ram_read_data<=0; access_err<=1 for one cycle. Otherwise access_err<=0 every edge.
- Back-to-back accesses:
  - A new request in the cycle after COMPLETE starts from cnt=0 and incurs the full WAIT_STATES again.
  - If an external stall holds the same request after COMPLETE, it is re-executed with full wait states. Reads and writes are idempotent, so this is harmless.
- Read-after-write to the same word in consecutive accesses returns the newly written data (write committed at the earlier edge).
- No combinational path from ram_read_data to stall. stall depends only on ram_en and cnt.

Test Plan:
1. WAIT_STATES=2, BASE=0: write 0xDEADBEEF to 0x10 with we=4'hF held -> stall high for 2 cycles, low on the 3rd; then read 0x10 -> after 2 stall cycles, ram_read_data=0xDEADBEEF one cycle after COMPLETE.
2. Byte lanes: word 0x20 holds 0x11223344; write we=4'b0010 data 0x0000AA00 -> subsequent read returns 0x1122AA44.
3. Out of range: read 0x0001_0000 with ADDR_WIDTH=10 -> ram_read_data=0 and access_err pulses exactly one cycle; write there leaves all in-range words unchanged.
4. Abort: ram_en drops after 1 stall cycle of a write to 0x30 (old value 0x0) -> stall falls immediately, cnt=0, a later read of 0x30 returns 0x0.
5. Reset mid-access: assert rst asynchronously during cnt=1 of a write -> stall and ram_read_data go to 0 without a clock edge; the write is not committed.
6. WAIT_STATES=0: back-to-back write then read of 0x40 with value 0x12345678 -> stall never asserted; read data 0x12345678 one cycle after the read edge.

Source files
------------

// File: rtl/data_ram_responder_if.sv
// data_ram_responder_if
//   RAM control port between the core MEM stage (master) and the data RAM
//   responder (slave).
//
//   Handshake: the master raises ram_en together with a stable
//   ram_write_en/ram_addr/ram_write_data and keeps all of them unchanged while
//   stall is high. The access takes effect on the first rising edge at which
//   ram_en=1 and stall=0. Read data appears on ram_read_data in the cycle
//   after that edge. access_err pulses in the same cycle for an address
//   outside the RAM window. Dropping ram_en while stall is high abandons the
//   request with no side effects.
//
//   Signals:
//     ram_en          master->slave  access request
//     ram_write_en    master->slave  byte-lane write enables, 0 = read
//     ram_addr        master->slave  byte address, bits [1:0] ignored
//     ram_write_data  master->slave  lane-aligned write data
//     ram_read_data   slave->master  registered read word
//     stall           slave->master  wait request (combinational)
//     access_err      slave->master  one-cycle out-of-window pulse
interface data_ram_responder_if;
  logic        ram_en;
  logic [3:0]  ram_write_en;
  logic [31:0] ram_addr;
  logic [31:0] ram_write_data;
  logic [31:0] ram_read_data;
  logic        stall;
  logic        access_err;

  modport master (
    output ram_en, ram_write_en, ram_addr, ram_write_data,
    input  ram_read_data, stall, access_err
  );

  modport slave (
    input  ram_en, ram_write_en, ram_addr, ram_write_data,
    output ram_read_data, stall, access_err
  );
endinterface

// File: rtl/data_ram_responder.sv
// data_ram_responder
//   Word-organised data RAM with per-byte write lanes, serving the core RAM
//   control port. Every access is held off for WAIT_STATES cycles by driving
//   stall, which models slower memory without touching the pipeline.
//
//   Ports:
//     clk      rising-edge clock
//     rst      asynchronous active-high reset
//     bus      data_ram_responder_if.slave (request in, read data/stall/err out)
//     dbg_cnt  current wait counter value (0..WAIT_STATES)
//
//   Parameters:
//     ADDR_WIDTH   word-address width, RAM holds 2^ADDR_WIDTH 32-bit words
//     WAIT_STATES  stall cycles per access (0..15)
//     BASE_ADDR    byte base of the RAM window, aligned to 2^(ADDR_WIDTH+2)
module data_ram_responder #(
  parameter int          ADDR_WIDTH  = 10,
  parameter int          WAIT_STATES = 2,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic                 clk,
  input  logic                 rst,
  data_ram_responder_if.slave  bus,
  output logic [3:0]           dbg_cnt
);
  localparam int         DEPTH    = 1 << ADDR_WIDTH;
  localparam logic [3:0] LAST_CNT = 4'(WAIT_STATES);

  logic [31:0]           mem [DEPTH];
  logic [3:0]            cnt;
  logic [31:0]           read_data_q;
  logic                  access_err_q;
  logic                  in_range;
  logic                  is_read;
  logic                  complete;
  logic [ADDR_WIDTH-1:0] word_idx;
  logic                  unused_addr_bits;

  assign in_range         = (bus.ram_addr[31:ADDR_WIDTH+2] == BASE_ADDR[31:ADDR_WIDTH+2]);
  assign word_idx         = bus.ram_addr[ADDR_WIDTH+1:2];
  assign is_read          = (bus.ram_write_en == 4'b0000);
  assign complete         = bus.ram_en && (cnt == LAST_CNT);
  // Byte offset within the word plays no part in a word-organised RAM.
  assign unused_addr_bits = ^bus.ram_addr[1:0];

  // The wait request is a pure function of the request and the counter, so
  // no path exists from read data to stall. Reset forces it low at once even
  // if the core is still presenting a request.
  assign bus.stall         = bus.ram_en && !rst && (cnt != LAST_CNT);
  assign bus.ram_read_data = read_data_q;
  assign bus.access_err    = access_err_q;
  assign dbg_cnt           = cnt;

  // Array contents survive reset; a write only lands on a completing edge
  // with reset inactive, so an access interrupted by reset never commits.
  always_ff @(posedge clk) begin
    if (complete && in_range && !is_read && !rst) begin
      for (int i = 0; i < 4; i++) begin
        if (bus.ram_write_en[i]) begin
          mem[word_idx][8*i +: 8] <= bus.ram_write_data[8*i +: 8];
        end
      end
    end
  end

  // Wait counter: counts up while a request is pending, wraps to 0 on the
  // completing edge, and clears whenever the request disappears (abort).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt          <= 4'd0;
      read_data_q  <= 32'h0;
      access_err_q <= 1'b0;
    end else begin
      access_err_q <= 1'b0;
      if (!bus.ram_en) begin
        cnt <= 4'd0;
      end else if (cnt != LAST_CNT) begin
        cnt <= cnt + 4'd1;
      end else begin
        cnt <= 4'd0;
        if (!in_range) begin
          access_err_q <= 1'b1;
          if (is_read) begin
            read_data_q <= 32'h0;
          end
        end else if (is_read) begin
          read_data_q <= mem[word_idx];
        end
      end
    end
  end
endmodule
